// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared FSM states, PC step and queue entry layout
package pipe_pkg;

  typedef enum logic {
    RUN     = 1'b0,
    RECOVER = 1'b1
  } state_e;

  localparam logic [31:0] PC_INC  = 32'd4;
  localparam int          ENTRY_W = 65;

  // Entry layout is {pc, taken, target}; 65 bits total.
  typedef struct packed {
    logic [31:0] pc;
    logic        taken;
    logic [31:0] target;
  } pred_entry_t;

endpackage

// File: rtl/branch_pred_fifo.sv
// rtl/branch_pred_fifo.sv - in-flight branch prediction queue
module branch_pred_fifo
  import pipe_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = ENTRY_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic                       clear_i,
  input  logic [W-1:0]               wdata_i,
  output logic [W-1:0]               rdata_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q;

  // Storage, pointers and occupancy; clear wins over push/pop (flush of wrong path).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop_i) rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/branch_redirect_ctrl.sv
// rtl/branch_redirect_ctrl.sv - branch resolution, redirect and predictor training control
module branch_redirect_ctrl
  import pipe_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int RECOVER_CYC = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pred_valid,
  input  logic        pred_taken,
  input  logic [31:0] pred_pc,
  input  logic [31:0] pred_target,
  input  logic        ex_valid,
  input  logic        ex_taken,
  output logic        pred_ready,
  output logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        upd_we,
  output logic        upd_taken,
  output logic [31:0] upd_pc,
  output logic [15:0] branch_cnt,
  output logic [15:0] mispred_cnt,
  output logic        err_underflow,
  output logic        err_overflow
);

  localparam int          AW       = $clog2(DEPTH);
  localparam logic [2:0]  REC_LOAD = 3'(RECOVER_CYC - 1);

  state_e      state_q, state_d;
  logic [2:0]  rec_cnt_q, rec_cnt_d;

  pred_entry_t head;
  pred_entry_t wr_entry;
  logic [AW:0] fifo_count;
  logic        fifo_empty;
  logic        push, pop, mispred, in_run;

  logic        upd_we_q, upd_we_d;
  logic        upd_taken_q, upd_taken_d;
  logic [31:0] upd_pc_q, upd_pc_d;
  logic        flush_q, flush_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;
  logic [15:0] branch_cnt_q, branch_cnt_d;
  logic [15:0] mispred_cnt_q, mispred_cnt_d;
  logic        err_underflow_q, err_underflow_d;
  logic        err_overflow_q, err_overflow_d;

  assign wr_entry   = '{pc: pred_pc, taken: pred_taken, target: pred_target};
  assign pred_ready = (fifo_count < (AW+1)'(DEPTH)) && (state_q == RUN);

  branch_pred_fifo #(.DEPTH(DEPTH), .W(ENTRY_W)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .clear_i (mispred),
    .wdata_i (wr_entry),
    .rdata_o (head),
    .count_o (fifo_count),
    .empty_o (fifo_empty)
  );

  // Resolution decode, recovery FSM next state and next values of all registered outputs.
  always_comb begin
    in_run    = (state_q == RUN);
    pop       = ex_valid && in_run && !fifo_empty;
    mispred   = pop && (ex_taken != head.taken);
    push      = pred_valid && pred_ready && !mispred;

    state_d   = state_q;
    rec_cnt_d = rec_cnt_q;
    case (state_q)
      RUN: begin
        if (mispred) begin
          state_d   = RECOVER;
          rec_cnt_d = REC_LOAD;
        end
      end
      RECOVER: begin
        if (rec_cnt_q == 3'd0) state_d = RUN;
        else                   rec_cnt_d = rec_cnt_q - 3'd1;
      end
      default: state_d = RUN;
    endcase

    upd_we_d        = pop;
    upd_taken_d     = pop ? ex_taken : upd_taken_q;
    upd_pc_d        = pop ? head.pc  : upd_pc_q;
    flush_d         = mispred;
    redirect_pc_d   = redirect_pc_q;
    if (mispred) redirect_pc_d = ex_taken ? head.target : head.pc + PC_INC;
    branch_cnt_d    = (pop && branch_cnt_q != 16'hFFFF) ? branch_cnt_q + 16'd1 : branch_cnt_q;
    mispred_cnt_d   = (mispred && mispred_cnt_q != 16'hFFFF) ? mispred_cnt_q + 16'd1 : mispred_cnt_q;
    err_underflow_d = err_underflow_q | (ex_valid && !pop);
    err_overflow_d  = err_overflow_q | (pred_valid && !pred_ready && in_run);
  end

  // Recovery FSM state register; reset aborts any recovery in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= RUN;
      rec_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      rec_cnt_q <= rec_cnt_d;
    end
  end

  // Registered redirect, training, statistics and sticky error outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      upd_we_q        <= 1'b0;
      upd_taken_q     <= 1'b0;
      upd_pc_q        <= '0;
      flush_q         <= 1'b0;
      redirect_pc_q   <= '0;
      branch_cnt_q    <= '0;
      mispred_cnt_q   <= '0;
      err_underflow_q <= 1'b0;
      err_overflow_q  <= 1'b0;
    end else begin
      upd_we_q        <= upd_we_d;
      upd_taken_q     <= upd_taken_d;
      upd_pc_q        <= upd_pc_d;
      flush_q         <= flush_d;
      redirect_pc_q   <= redirect_pc_d;
      branch_cnt_q    <= branch_cnt_d;
      mispred_cnt_q   <= mispred_cnt_d;
      err_underflow_q <= err_underflow_d;
      err_overflow_q  <= err_overflow_d;
    end
  end

  assign upd_we         = upd_we_q;
  assign upd_taken      = upd_taken_q;
  assign upd_pc         = upd_pc_q;
  assign flush          = flush_q;
  assign redirect_valid = flush_q;
  assign redirect_pc    = redirect_pc_q;
  assign branch_cnt     = branch_cnt_q;
  assign mispred_cnt    = mispred_cnt_q;
  assign err_underflow  = err_underflow_q;
  assign err_overflow   = err_overflow_q;

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// tb/tb_branch_redirect_ctrl.sv - directed self-checking bench for branch_redirect_ctrl
module tb_branch_redirect_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        pred_valid, pred_taken, ex_valid, ex_taken;
  logic [31:0] pred_pc, pred_target;
  logic        pred_ready, flush, redirect_valid, upd_we, upd_taken;
  logic [31:0] redirect_pc, upd_pc;
  logic [15:0] branch_cnt, mispred_cnt;
  logic        err_underflow, err_overflow;

  int n_chk = 0;
  int n_err = 0;

  branch_redirect_ctrl #(.DEPTH(4), .RECOVER_CYC(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .pred_valid     (pred_valid),
    .pred_taken     (pred_taken),
    .pred_pc        (pred_pc),
    .pred_target    (pred_target),
    .ex_valid       (ex_valid),
    .ex_taken       (ex_taken),
    .pred_ready     (pred_ready),
    .flush          (flush),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .upd_we         (upd_we),
    .upd_taken      (upd_taken),
    .upd_pc         (upd_pc),
    .branch_cnt     (branch_cnt),
    .mispred_cnt    (mispred_cnt),
    .err_underflow  (err_underflow),
    .err_overflow   (err_overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    pred_valid  = 1'b0;
    pred_taken  = 1'b0;
    pred_pc     = '0;
    pred_target = '0;
    ex_valid    = 1'b0;
    ex_taken    = 1'b0;
  endtask

  task automatic push_only(input logic [31:0] pc, input logic t, input logic [31:0] tgt);
    pred_valid = 1'b1; pred_pc = pc; pred_taken = t; pred_target = tgt;
    tick();
    idle();
  endtask

  task automatic pop_only(input logic t);
    ex_valid = 1'b1; ex_taken = t;
    tick();
    idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    rst = 1'b1;
    tick(); tick();
    check("rst_flush", flush, 0);
    check("rst_redirect_valid", redirect_valid, 0);
    check("rst_upd_we", upd_we, 0);
    check("rst_branch_cnt", branch_cnt, 0);
    check("rst_err_underflow", err_underflow, 0);
    rst = 1'b0;
    #1;
    check("ready_after_release", pred_ready, 1);

    // Correct taken prediction trains predictor, no flush.
    push_only(32'h100, 1'b1, 32'h140);
    pop_only(1'b1);
    check("t1_upd_we", upd_we, 1);
    check("t1_upd_pc", upd_pc, 32'h100);
    check("t1_upd_taken", upd_taken, 1);
    check("t1_no_flush", flush, 0);
    check("t1_branch_cnt", branch_cnt, 1);
    tick();
    check("t1_upd_we_drop", upd_we, 0);

    // Predicted taken, resolved not-taken: redirect to pc+4, recovery blocks fetch.
    push_only(32'h200, 1'b1, 32'h180);
    ex_valid = 1'b1; ex_taken = 1'b0;
    #1;
    check("t2_ready_before", pred_ready, 1);
    tick();
    idle();
    #1;
    check("t2_flush", flush, 1);
    check("t2_redirect_valid", redirect_valid, 1);
    check("t2_redirect_pc", redirect_pc, 32'h204);
    check("t2_mispred_cnt", mispred_cnt, 1);
    check("t2_upd_pc", upd_pc, 32'h200);
    check("t2_upd_taken", upd_taken, 0);
    check("t2_ready_rec1", pred_ready, 0);
    tick();
    check("t2_flush_one_cycle", flush, 0);
    check("t2_ready_rec2", pred_ready, 0);
    tick();
    check("t2_ready_back", pred_ready, 1);

    // Predicted not-taken, resolved taken: redirect to target.
    push_only(32'h300, 1'b0, 32'h3A0);
    pop_only(1'b1);
    check("t2b_redirect_pc", redirect_pc, 32'h3A0);
    check("t2b_flush", flush, 1);
    tick(); tick();
    check("t2b_mispred_cnt", mispred_cnt, 2);
    check("t2b_branch_cnt", branch_cnt, 3);

    // Fill to DEPTH, push+pop same cycle, overflow attempt, FIFO order on drain.
    push_only(32'h400, 1'b1, 32'h0);
    push_only(32'h410, 1'b0, 32'h0);
    push_only(32'h420, 1'b1, 32'h0);
    push_only(32'h430, 1'b0, 32'h0);
    check("t3_full_ready", pred_ready, 0);
    check("t3_no_ovf_full", err_overflow, 0);
    pop_only(1'b1);
    check("t3_pop_400", upd_pc, 32'h400);
    check("t3_ready_after_pop", pred_ready, 1);
    pred_valid = 1'b1; pred_pc = 32'h440; pred_taken = 1'b1;
    ex_valid = 1'b1; ex_taken = 1'b0;
    tick();
    idle();
    check("t3_pushpop_410", upd_pc, 32'h410);
    check("t3_pushpop_no_flush", flush, 0);
    check("t3_pushpop_ready", pred_ready, 1);
    push_only(32'h450, 1'b0, 32'h0);
    check("t3_refull_ready", pred_ready, 0);
    check("t3_no_ovf", err_overflow, 0);
    pred_valid = 1'b1; pred_pc = 32'h460;
    tick();
    idle();
    check("t3_ovf_set", err_overflow, 1);
    pop_only(1'b1); check("t3_drain_420", upd_pc, 32'h420);
    pop_only(1'b0); check("t3_drain_430", upd_pc, 32'h430);
    pop_only(1'b1); check("t3_drain_440", upd_pc, 32'h440);
    pop_only(1'b0); check("t3_drain_450", upd_pc, 32'h450);
    check("t3_no_flush", flush, 0);
    check("t3_branch_cnt", branch_cnt, 9);
    check("t3_mispred_cnt", mispred_cnt, 2);
    check("t3_no_underflow", err_underflow, 0);

    // Oldest of three mispredicts with a wrong-path push in the same cycle.
    push_only(32'h500, 1'b1, 32'h5F0);
    push_only(32'h510, 1'b0, 32'h0);
    push_only(32'h520, 1'b1, 32'h0);
    ex_valid = 1'b1; ex_taken = 1'b0;
    pred_valid = 1'b1; pred_pc = 32'h530; pred_taken = 1'b0; pred_target = 32'h5A0;
    tick();
    idle();
    check("t4_flush", flush, 1);
    check("t4_redirect_pc", redirect_pc, 32'h504);
    check("t4_mispred_cnt", mispred_cnt, 3);
    check("t4_branch_cnt", branch_cnt, 10);
    tick(); tick();
    pop_only(1'b0);
    check("t4_empty_no_upd", upd_we, 0);
    check("t4_underflow", err_underflow, 1);
    check("t4_branch_cnt_hold", branch_cnt, 10);
    tick();
    check("t4_underflow_sticky", err_underflow, 1);

    // Reset asserted during recovery.
    push_only(32'h600, 1'b1, 32'h640);
    pop_only(1'b0);
    check("t5_flush", flush, 1);
    check("t5_redirect_pc", redirect_pc, 32'h604);
    #2;
    rst = 1'b1;
    #1;
    check("t5_rst_flush", flush, 0);
    check("t5_rst_redirect_valid", redirect_valid, 0);
    check("t5_rst_redirect_pc", redirect_pc, 0);
    check("t5_rst_upd_we", upd_we, 0);
    check("t5_rst_upd_pc", upd_pc, 0);
    check("t5_rst_mispred_cnt", mispred_cnt, 0);
    check("t5_rst_branch_cnt", branch_cnt, 0);
    check("t5_rst_underflow", err_underflow, 0);
    check("t5_rst_overflow", err_overflow, 0);
    tick();
    rst = 1'b0;
    #1;
    check("t5_ready_run", pred_ready, 1);
    tick();
    check("t5_no_flush_a", flush, 0);
    tick();
    check("t5_no_flush_b", flush, 0);

    // Saturation of mispred_cnt, starting close to the limit.
    force dut.mispred_cnt_q = 16'hFFFD;
    tick();
    release dut.mispred_cnt_q;
    #1;
    check("t6_preload", mispred_cnt, 32'hFFFD);
    for (int i = 0; i < 3; i++) begin
      push_only(32'h700 + 32'(i * 16), 1'b1, 32'h780);
      pop_only(1'b0);
      check("t6_sat", mispred_cnt, (i == 0) ? 32'hFFFE : 32'hFFFF);
      tick(); tick();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
